// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel divider, h/v counters with porch/sync FSMs, registered DAC outputs.
// Define VGA_FRAME_CNT_EN to add the 16-bit frame_cnt output.
module vga_sync_gen #(
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FRONT  = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BACK   = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FRONT  = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BACK   = 33
) (
    input  logic       clk,
    input  logic       reset,
    output logic [9:0] h_counter,
    output logic [9:0] v_counter,
    output logic       pixel_tick,
    output logic       frame_start,
    input  logic [7:0] R_in,
    input  logic [7:0] G_in,
    input  logic [7:0] B_in,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N,
    output logic       VGA_CLK
`ifdef VGA_FRAME_CNT_EN
    ,output logic [15:0] frame_cnt
`endif
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_CLK_HI = DIV_W'(CLK_DIV - CLK_DIV / 2);

    localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_B_FRONT = 10'(H_ACTIVE);
    localparam logic [9:0] H_B_SYNC  = 10'(H_ACTIVE + H_FRONT);
    localparam logic [9:0] H_B_BACK  = 10'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_B_FRONT = 10'(V_ACTIVE);
    localparam logic [9:0] V_B_SYNC  = 10'(V_ACTIVE + V_FRONT);
    localparam logic [9:0] V_B_BACK  = 10'(V_ACTIVE + V_FRONT + V_SYNC);

    typedef enum logic [1:0] {ACTIVE, FRONT, SYNC, BACK} state_e;

    // State always describes the counter value it sits beside, so it is
    // decoded from the counter's next value at each boundary.
    function automatic state_e next_state(input logic [9:0] c, input state_e cur,
                                          input logic [9:0] b_front, input logic [9:0] b_sync,
                                          input logic [9:0] b_back);
        next_state = cur;
        if (c == '0)           next_state = ACTIVE;
        else if (c == b_front) next_state = FRONT;
        else if (c == b_sync)  next_state = SYNC;
        else if (c == b_back)  next_state = BACK;
    endfunction

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       h_q, h_d, v_q, v_d;
    state_e           hst_q, hst_d, vst_q, vst_d;
    logic             frame_start_q, frame_start_d;
    logic [7:0]       r_q, r_d, g_q, g_d, b_q, b_d;
    logic             hs_q, hs_d, vs_q, vs_d, blank_n_q, blank_n_d;
    logic             tick, h_wrap, v_wrap, active;
`ifdef VGA_FRAME_CNT_EN
    logic [15:0]      frame_cnt_q, frame_cnt_d;
`endif

    assign tick   = (div_q == DIV_LAST);
    assign h_wrap = (h_q == H_LAST);
    assign v_wrap = (v_q == V_LAST);
    assign active = (hst_q == ACTIVE) && (vst_q == ACTIVE);

    always_comb begin
        div_d         = tick ? '0 : div_q + 1'b1;
        h_d           = h_q;
        v_d           = v_q;
        hst_d         = hst_q;
        vst_d         = vst_q;
        frame_start_d = 1'b0;
        r_d           = r_q;
        g_d           = g_q;
        b_d           = b_q;
        hs_d          = hs_q;
        vs_d          = vs_q;
        blank_n_d     = blank_n_q;
        if (tick) begin
            // DAC captures the pixel that is ending, before the counters move on.
            hs_d      = (hst_q != SYNC);
            vs_d      = (vst_q != SYNC);
            blank_n_d = active;
            r_d       = active ? R_in : '0;
            g_d       = active ? G_in : '0;
            b_d       = active ? B_in : '0;
            h_d       = h_wrap ? '0 : h_q + 10'd1;
            if (h_wrap)
                v_d = v_wrap ? '0 : v_q + 10'd1;
            frame_start_d = h_wrap && v_wrap;
            hst_d = next_state(h_d, hst_q, H_B_FRONT, H_B_SYNC, H_B_BACK);
            vst_d = next_state(v_d, vst_q, V_B_FRONT, V_B_SYNC, V_B_BACK);
        end
`ifdef VGA_FRAME_CNT_EN
        frame_cnt_d = frame_cnt_q + (frame_start_d ? 16'd1 : 16'd0);
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q         <= '0;
            h_q           <= '0;
            v_q           <= '0;
            hst_q         <= ACTIVE;
            vst_q         <= ACTIVE;
            frame_start_q <= 1'b0;
            r_q           <= '0;
            g_q           <= '0;
            b_q           <= '0;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            blank_n_q     <= 1'b0;
`ifdef VGA_FRAME_CNT_EN
            frame_cnt_q   <= '0;
`endif
        end else begin
            div_q         <= div_d;
            h_q           <= h_d;
            v_q           <= v_d;
            hst_q         <= hst_d;
            vst_q         <= vst_d;
            frame_start_q <= frame_start_d;
            r_q           <= r_d;
            g_q           <= g_d;
            b_q           <= b_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            blank_n_q     <= blank_n_d;
`ifdef VGA_FRAME_CNT_EN
            frame_cnt_q   <= frame_cnt_d;
`endif
        end
    end

    assign h_counter   = h_q;
    assign v_counter   = v_q;
    assign pixel_tick  = tick;
    assign frame_start = frame_start_q;
    assign VGA_R       = r_q;
    assign VGA_G       = g_q;
    assign VGA_B       = b_q;
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign VGA_BLANK_N = blank_n_q;
    assign VGA_SYNC_N  = 1'b0;
    assign VGA_CLK     = (div_q >= DIV_CLK_HI);
`ifdef VGA_FRAME_CNT_EN
    assign frame_cnt   = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: default horizontal timing, shortened vertical timing (15 lines).
module tb_vga_sync_gen;

    localparam int HT = 800;
    localparam int VT = 15;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] h_counter, v_counter;
    logic       pixel_tick, frame_start;
    logic [7:0] R_in = 8'hFF, G_in = 8'h5A, B_in = 8'hC3;
    logic [7:0] VGA_R, VGA_G, VGA_B;
    logic       VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_CLK;
`ifdef VGA_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    vga_sync_gen #(
        .CLK_DIV(2), .H_ACTIVE(640), .H_FRONT(16), .H_SYNC(96), .H_BACK(48),
        .V_ACTIVE(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
    ) dut (
        .clk(clk), .reset(reset), .h_counter(h_counter), .v_counter(v_counter),
        .pixel_tick(pixel_tick), .frame_start(frame_start),
        .R_in(R_in), .G_in(G_in), .B_in(B_in),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N),
        .VGA_SYNC_N(VGA_SYNC_N), .VGA_CLK(VGA_CLK)
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int cyc = 0, fs_cyc = 0, fs_count = 0, rel_cyc = 0;
    int exp_h = 0, exp_v = 0, cnt_err = 0;
    int hs_low = 0, hs_first = -1, vs_low = 0, vs_first_v = -1, vs_first_h = -1;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (frame_start === 1'b1) begin
            fs_count++;
            fs_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic next_tick;
        int unsigned n = 0;
        while (pixel_tick !== 1'b1 && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        if (pixel_tick !== 1'b1) chk("tick_timeout", 32'(pixel_tick), 1);
        @(posedge clk); #1;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_h"}, h_counter, 0);
        chk({tag, "_v"}, v_counter, 0);
        chk({tag, "_tick"}, pixel_tick, 0);
        chk({tag, "_fs"}, frame_start, 0);
        chk({tag, "_rgb"}, {VGA_R, VGA_G, VGA_B}, 0);
        chk({tag, "_hs"}, VGA_HS, 1);
        chk({tag, "_vs"}, VGA_VS, 1);
        chk({tag, "_blank"}, VGA_BLANK_N, 0);
        chk({tag, "_vclk"}, VGA_CLK, 0);
        chk({tag, "_syncn"}, VGA_SYNC_N, 0);
`ifdef VGA_FRAME_CNT_EN
        chk({tag, "_fcnt"}, frame_cnt, 0);
`endif
    endtask

    // Each tick ends pixel (ph,pv); outputs sampled afterwards describe that pixel.
    task automatic run_ticks(input int n);
        int ph, pv;
        for (int i = 0; i < n; i++) begin
            ph = exp_h;
            pv = exp_v;
            next_tick;
            exp_h++;
            if (exp_h == HT) begin
                exp_h = 0;
                exp_v = (exp_v == VT - 1) ? 0 : exp_v + 1;
            end
            if (h_counter !== 10'(exp_h) || v_counter !== 10'(exp_v)) cnt_err++;
            if (VGA_HS === 1'b0) begin
                if (hs_low == 0) hs_first = ph;
                hs_low++;
            end
            if (VGA_VS === 1'b0) begin
                if (vs_low == 0) begin vs_first_v = pv; vs_first_h = ph; end
                vs_low++;
            end
            if (pv == 5 && ph == 100) begin
                chk("act_r", VGA_R, 8'hFF);
                chk("act_g", VGA_G, 8'h5A);
                chk("act_b", VGA_B, 8'hC3);
                chk("act_blank", VGA_BLANK_N, 1);
            end
            if (pv == 5 && ph == 700) begin
                chk("hblank_r", VGA_R, 0);
                chk("hblank_blank", VGA_BLANK_N, 0);
            end
            if (pv == 7 && ph == 639) chk("last_act_blank", VGA_BLANK_N, 1);
            if (pv == 7 && ph == 640) chk("first_front_blank", VGA_BLANK_N, 0);
            if (pv == 8 && ph == 100) begin
                chk("vblank_r", VGA_R, 0);
                chk("vblank_blank", VGA_BLANK_N, 0);
            end
            if (pv == 1 && ph == 0) chk("fs_idle", frame_start, 0);
            if (ph == HT - 1) begin
                chk("hs_len", hs_low, 96);
                chk("hs_start", hs_first, 656);
                hs_low = 0;
                hs_first = -1;
            end
            if (ph == HT - 1 && pv == 0) begin
                chk("hwrap_h", h_counter, 0);
                chk("hwrap_v", v_counter, 1);
            end
            if (ph == HT - 1 && pv == VT - 1) begin
                chk("vs_len", vs_low, 1600);
                chk("vs_start_v", vs_first_v, 10);
                chk("vs_start_h", vs_first_h, 0);
                chk("fwrap_fs", frame_start, 1);
                chk("fwrap_hv", {h_counter, v_counter}, 0);
                vs_low = 0;
                vs_first_v = -1;
                vs_first_h = -1;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 check_reset_values("rst0");

        @(negedge clk) reset = 1'b0;
        rel_cyc = cyc;
        @(posedge clk); #1;
        chk("e1_tick", pixel_tick, 1);
        chk("e1_h", h_counter, 0);
        chk("e1_vclk", VGA_CLK, 1);
        @(posedge clk); #1;
        chk("e2_tick", pixel_tick, 0);
        chk("e2_h", h_counter, 1);
        chk("e2_vclk", VGA_CLK, 0);
        @(posedge clk); #1;
        chk("e3_tick", pixel_tick, 1);
        @(posedge clk); #1;
        chk("e4_h", h_counter, 2);
        exp_h = 2;
        exp_v = 0;

        run_ticks(HT * VT - 2);
        @(negedge clk); #1;
        chk("fs_period0", fs_cyc - rel_cyc, 24000);
`ifdef VGA_FRAME_CNT_EN
        chk("fcnt_1", frame_cnt, 1);
`endif

        run_ticks(5 * HT + 300);
        chk("pre_rst_hv", {h_counter, v_counter}, {10'd300, 10'd5});
        #2 reset = 1'b1;
        #1 check_reset_values("rst_mid");
        repeat (2) @(posedge clk);
        #1 check_reset_values("rst_hold");
        hs_low = 0;
        hs_first = -1;
        vs_low = 0;

        @(negedge clk) reset = 1'b0;
        rel_cyc = cyc;
        @(posedge clk); #1;
        chk("r1_tick", pixel_tick, 1);
        chk("r1_h", h_counter, 0);
        @(posedge clk); #1;
        chk("r2_hv", {h_counter, v_counter}, {10'd1, 10'd0});
        exp_h = 1;
        exp_v = 0;

        run_ticks(HT * VT - 1);
        @(negedge clk); #1;
        chk("fs_period1", fs_cyc - rel_cyc, 24000);
`ifdef VGA_FRAME_CNT_EN
        chk("fcnt_after_rst", frame_cnt, 1);
`endif
        chk("counters", cnt_err, 0);
        chk("fs_count", fs_count, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
